seq_det_ctrl: RTL
=================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of match counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a frame.
REQ-005 cfg_pat  input  8  pattern; most recently received bit compares to bit 0.
REQ-006 cfg_len  input  3  pattern length minus 1 (1..8 bits).
REQ-007 cfg_frame  input  8  bits per frame; 0 means 256.
REQ-008 cfg_overlap  input  1  1 = overlapping matches counted; 0 = history cleared after each match.
REQ-009 bit_in  input  1  serial data bit.
REQ-010 bit_vld  input  1  bit_in valid.
REQ-011 bit_rdy  output  1  controller accepts a bit; a bit transfers when bit_vld and bit_rdy are both 1.
REQ-012 busy  output  1  high from start acceptance until the DONE cycle, inclusive.
REQ-013 match  output  1  registered one-cycle pulse per detected match.
REQ-014 match_cnt  output  CNT_W  matches in current or last frame.
REQ-015 done  output  1  one-cycle pulse at frame end.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start in IDLE; RUN->DONE on the cycle after the last frame bit is accepted; DONE->IDLE unconditionally after one cycle.
REQ-017 start is accepted only in IDLE; start in RUN or DONE is ignored.
REQ-018 On start acceptance, cfg_pat, cfg_len, cfg_frame, cfg_overlap are latched; cfg changes during RUN have no effect.
REQ-019 On start acceptance, history, bits-seen count, frame bit counter, and match_cnt clear to 0.
REQ-020 bit_rdy = 1 exactly in RUN; busy = 1 in RUN and DONE.
REQ-021 Each accepted bit shifts into an 8-bit history at bit 0 (older bits move toward bit 7); bits-seen increments, saturating at 8.
REQ-022 Match occurs when the new history bits [cfg_len:0] equal cfg_pat[cfg_len:0] and bits-seen (including the new bit) exceeds cfg_len.
REQ-023 match is asserted the cycle after the completing bit's acceptance; latency is exactly 1 cycle.
REQ-024 With cfg_overlap=0, a match clears bits-seen to 0, so the next match needs cfg_len+1 fresh bits.
REQ-025 match_cnt increments in the same cycle match is asserted, saturates at 2^CNT_W-1, and holds until the next start acceptance.
REQ-026 The frame ends when accepted bits equal cfg_frame (256 when 0); no bit is accepted after the last one.
REQ-027 done is asserted in the DONE state, i.e. the same cycle as match for the final bit.
REQ-028 Cycles with bit_vld=0 in RUN consume nothing and change no state.
REQ-029 bit_in is ignored whenever no transfer occurs.

Reset
REQ-030 While rst=1 at a clock edge: state IDLE; busy, bit_rdy, match, done = 0; match_cnt, history, counters = 0; latched config = 0.
REQ-031 rst in any state, including mid-frame, aborts the frame with no done pulse.
REQ-032 rst has priority over start and bit transfer in the same cycle.

Verification
REQ-033 Reset: rst=1 for 2 cycles -> busy=0, bit_rdy=0, match=0, done=0, match_cnt=0.
REQ-034 Overlap: cfg_pat=8'h0D, cfg_len=3, cfg_frame=8, cfg_overlap=1; stream 1,1,0,1,1,0,1,0 -> match after bits 4 and 7; match_cnt=2; done 1 cycle after bit 8.
REQ-035 Non-overlap: same stream with cfg_overlap=0 -> single match after bit 4; match_cnt=1.
REQ-036 Handshake and config: 3-cycle bit_vld gaps mid-frame, plus start and changed cfg asserted during RUN -> results identical to REQ-034; second start ignored.
REQ-037 Saturation and frame=0: cfg_pat=8'h01, cfg_len=0, cfg_frame=0, all-ones stream -> match every accepted bit; match_cnt stops at 255; done after bit 256.
REQ-038 Mid-frame reset: rst after bit 3 of REQ-034 -> all outputs 0, no done; a new start then gives REQ-034 results.

Source files
------------

// File: rtl/seq_det_if.sv
// Serial pattern detector bus: frame control, config, bit stream and results.
interface seq_det_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [7:0]       cfg_pat;
   logic [2:0]       cfg_len;
   logic [7:0]       cfg_frame;
   logic             cfg_overlap;
   logic             bit_in;
   logic             bit_vld;
   logic             bit_rdy;
   logic             busy;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             done;

   modport master (
      output start, cfg_pat, cfg_len, cfg_frame, cfg_overlap,
      output bit_in, bit_vld,
      input  bit_rdy, busy, match, match_cnt, done
   );

   modport slave (
      input  start, cfg_pat, cfg_len, cfg_frame, cfg_overlap,
      input  bit_in, bit_vld,
      output bit_rdy, busy, match, match_cnt, done
   );
endinterface

// File: rtl/seq_det_ctrl.sv
// Framed serial pattern detector: counts pattern hits over a frame of bits.
module seq_det_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic      clk,
   input  logic      rst,
   seq_det_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       pat_q, pat_d;
   logic [2:0]       len_q, len_d;
   logic [7:0]       frame_q, frame_d;
   logic             ovl_q, ovl_d;
   logic [7:0]       hist_q, hist_d;
   logic [3:0]       seen_q, seen_d;
   logic [8:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match_q, match_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             rdy_q, rdy_d;

   logic [7:0]       hist_nx;
   logic [7:0]       mask;
   logic [3:0]       seen_nx;
   logic [8:0]       flen;
   logic [8:0]       fcnt_nx;
   logic             hit;

   always_comb begin
      hist_nx = {hist_q[6:0], bus.bit_in};
      seen_nx = (seen_q == 4'd8) ? seen_q : seen_q + 4'd1;
      mask    = 8'hff >> (3'd7 - len_q);
      hit     = (((hist_nx ^ pat_q) & mask) == 8'h00) &&
                (seen_nx > {1'b0, len_q});
      // a programmed frame length of 0 stands for 256 bits
      flen    = (frame_q == 8'd0) ? 9'd256 : {1'b0, frame_q};
      fcnt_nx = fcnt_q + 9'd1;

      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      frame_d = frame_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      seen_d  = seen_q;
      fcnt_d  = fcnt_q;
      cnt_d   = cnt_q;
      match_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               pat_d   = bus.cfg_pat;
               len_d   = bus.cfg_len;
               frame_d = bus.cfg_frame;
               ovl_d   = bus.cfg_overlap;
               hist_d  = 8'h00;
               seen_d  = 4'd0;
               fcnt_d  = 9'd0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (rdy_q && bus.bit_vld) begin
               hist_d  = hist_nx;
               seen_d  = (hit && !ovl_q) ? 4'd0 : seen_nx;
               match_d = hit;
               fcnt_d  = fcnt_nx;
               if (hit && (cnt_q != '1)) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (fcnt_nx == flen) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      rdy_d  = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= 8'h00;
         len_q   <= 3'd0;
         frame_q <= 8'h00;
         ovl_q   <= 1'b0;
         hist_q  <= 8'h00;
         seen_q  <= 4'd0;
         fcnt_q  <= 9'd0;
         cnt_q   <= '0;
         match_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         frame_q <= frame_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         seen_q  <= seen_d;
         fcnt_q  <= fcnt_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
      end
   end

   assign bus.bit_rdy   = rdy_q;
   assign bus.busy      = busy_q;
   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
   assign bus.done      = done_q;

endmodule
